// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with clear sequencer and NZP condition codes
//
// Purpose:
//   WIDTH-bit x DEPTH-entry register file with two read ports and one write
//   port. After reset, a sequencer zeroes one register per cycle. Writes are
//   accepted only once that sweep is complete. An LC-3 style {N,Z,P}
//   condition-code register is updated from the write data when requested.
//   With REG_OUT=1 the read ports are registered. A write that hits the
//   selected address on the same edge is bypassed into the read register.
//   With REG_OUT=0 the reads are combinational from the array.
//
// Ports:
//   clk               clock, all state updates on the rising edge
//   rst               synchronous active-high reset; restarts the clear sweep
//   load_reg          write enable (ignored until ready)
//   set_cc            update nzp from dr_in on an accepted write
//   dr_sel, dr_in     write address / data
//   sr1_sel, sr2_sel  read addresses
//   sr1_out, sr2_out  read data
//   nzp               condition codes {N,Z,P}
//   ready             high once the clear sweep has finished
module regfile_mp #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int REG_OUT = 1,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_reg,
  input  logic             set_cc,
  input  logic [AW-1:0]    dr_sel,
  input  logic [WIDTH-1:0] dr_in,
  input  logic [AW-1:0]    sr1_sel,
  input  logic [AW-1:0]    sr2_sel,
  output logic [WIDTH-1:0] sr1_out,
  output logic [WIDTH-1:0] sr2_out,
  output logic [2:0]       nzp,
  output logic             ready
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clear_idx_q, clear_idx_d;
  logic            wr_en;
  logic [2:0]      nzp_q;
  logic [2:0]      cc_new;
  logic [WIDTH-1:0] regs [DEPTH];

  // ---------------------------------------------------------------------------
  // Clear/run sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    case (state_q)
      S_CLEAR: begin
        clear_idx_d = clear_idx_q + 1'b1;
        // Leave CLEAR on the same edge that zeroes the last entry.
        if (clear_idx_q == AW'(DEPTH - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d     = S_CLEAR;
        clear_idx_d = '0;
      end
    endcase
  end

  assign ready = (state_q == S_RUN);

  // Reset wins over a write issued on the same edge. Writes seen during
  // the clear sweep are dropped rather than queued.
  assign wr_en = ready && load_reg && !rst;

  // ---------------------------------------------------------------------------
  // Register array: the clear sweep and user writes share the single write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        regs[clear_idx_q] <= '0;
      end else if (wr_en) begin
        regs[dr_sel] <= dr_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Condition codes: dr_in is treated as a signed WIDTH-bit value
  // ---------------------------------------------------------------------------
  always_comb begin
    cc_new = 3'b001;
    if (dr_in[WIDTH-1]) begin
      cc_new = 3'b100;
    end else if (dr_in == '0) begin
      cc_new = 3'b010;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nzp_q <= 3'b010;
    end else if (wr_en && set_cc) begin
      nzp_q <= cc_new;
    end
  end

  assign nzp = nzp_q;

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] sr1_q;
    logic [WIDTH-1:0] sr2_q;

    // The array write lands on the same edge as this load. Forward dr_in so
    // that a port reading the written address sees the new value.
    always_ff @(posedge clk) begin
      if (rst || !ready) begin
        sr1_q <= '0;
        sr2_q <= '0;
      end else begin
        sr1_q <= (wr_en && (dr_sel == sr1_sel)) ? dr_in : regs[sr1_sel];
        sr2_q <= (wr_en && (dr_sel == sr2_sel)) ? dr_in : regs[sr2_sel];
      end
    end

    assign sr1_out = sr1_q;
    assign sr2_out = sr2_q;
  end else begin : g_comb_out
    assign sr1_out = regs[sr1_sel];
    assign sr2_out = regs[sr2_sel];
  end

endmodule
